led_pattern_gen: RTL

LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

---
 rtl/led_pattern_gen_pkg.sv | 11 +
 rtl/led_pattern_gen_if.sv | 12 +
 rtl/led_pattern_gen_channel.sv | 70 +++++++
 rtl/led_pattern_gen.sv | 49 ++++
 4 files changed

// File: rtl/led_pattern_gen_pkg.sv
// led_pattern_gen_pkg: mode encoding and field widths shared by the LED pattern generator
package led_pattern_gen_pkg;
    localparam int PERIOD_W = 16;
    localparam int DUTY_W = 8;
    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_t;
endpackage

// File: rtl/led_pattern_gen_if.sv
// led_pattern_gen_if: channel configuration write port with ack/err response pulses
interface led_pattern_gen_if;
    import led_pattern_gen_pkg::*;
    logic                we;
    logic [3:0]          ch;
    logic [1:0]          mode;
    logic [PERIOD_W-1:0] period;
    logic                ack;
    logic                err;
    modport master (output we, ch, mode, period, input ack, err);
    modport slave (input we, ch, mode, period, output ack, err);
endinterface

// File: rtl/led_pattern_gen_channel.sv
// led_channel: one LED engine (off/on/blink/breathe) stepped by the shared tick and pwm counter
module led_channel
    import led_pattern_gen_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick,
    input  logic                wr,
    input  mode_t               wr_mode,
    input  logic [PERIOD_W-1:0] wr_period,
    input  logic [DUTY_W-1:0]   pwm_cnt,
    output logic                led
);
    mode_t               mode, mode_nx;
    logic [PERIOD_W-1:0] period, period_nx, tcnt, tcnt_nx, eff_period;
    logic [DUTY_W-1:0]   duty, duty_nx, duty_step;
    logic                phase, phase_nx, down, down_nx, running, wrap, lit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode   <= MODE_OFF;
            period <= PERIOD_W'(1);
            tcnt   <= '0;
            phase  <= 1'b1;
            duty   <= '0;
            down   <= 1'b0;
            led    <= ACTIVE_LOW;
        end else begin
            mode   <= mode_nx;
            period <= period_nx;
            tcnt   <= tcnt_nx;
            phase  <= phase_nx;
            duty   <= duty_nx;
            down   <= down_nx;
            led    <= lit ^ ACTIVE_LOW;
        end
    end

    always_comb begin
        eff_period = period == '0 ? PERIOD_W'(1) : period;
        running    = mode == MODE_BLINK || mode == MODE_BREATHE;
        wrap       = tcnt == eff_period - PERIOD_W'(1);
        duty_step  = down ? duty - DUTY_W'(1) : duty + DUTY_W'(1);
        mode_nx    = mode;
        period_nx  = period;
        tcnt_nx    = tcnt;
        phase_nx   = phase;
        duty_nx    = duty;
        down_nx    = down;
        // a write restarts the pattern and swallows any tick landing on the same edge
        if (wr) begin
            mode_nx   = wr_mode;
            period_nx = wr_period;
            tcnt_nx   = '0;
            phase_nx  = 1'b1;
            duty_nx   = '0;
            down_nx   = 1'b0;
        end else if (tick && running) begin
            tcnt_nx = wrap ? '0 : tcnt + PERIOD_W'(1);
            if (wrap && mode == MODE_BLINK) phase_nx = !phase;
            if (wrap && mode == MODE_BREATHE) begin
                duty_nx = duty_step;
                down_nx = duty_step == '1 || (down && duty_step != '0);
            end
        end
        lit = mode == MODE_ON || (mode == MODE_BLINK && phase) || (mode == MODE_BREATHE && pwm_cnt < duty);
    end
endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: N_CH LED pattern channels sharing a tick prescaler, pwm counter and cfg decode
module led_pattern_gen
    import led_pattern_gen_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int TICK_DIV   = 50_000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    led_pattern_gen_if.slave  cfg,
    output logic [N_CH-1:0]   led
);
    localparam int PW = $clog2(TICK_DIV);

    logic [PW-1:0]     pre;
    logic [DUTY_W-1:0] pwm_cnt;
    logic              tick, valid;

    assign tick  = pre == PW'(TICK_DIV - 1);
    assign valid = {1'b0, cfg.ch} < 5'(N_CH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre     <= '0;
            pwm_cnt <= '0;
            cfg.ack <= 1'b0;
            cfg.err <= 1'b0;
        end else begin
            pre     <= tick ? '0 : pre + PW'(1);
            pwm_cnt <= pwm_cnt + DUTY_W'(1);
            cfg.ack <= cfg.we && valid;
            cfg.err <= cfg.we && !valid;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        led_channel #(.ACTIVE_LOW(ACTIVE_LOW)) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .tick      (tick),
            .wr        (cfg.we && valid && cfg.ch == 4'(i)),
            .wr_mode   (mode_t'(cfg.mode)),
            .wr_period (cfg.period),
            .pwm_cnt   (pwm_cnt),
            .led       (led[i])
        );
    end
endmodule
